bus_seq: RTL and testbench
==========================

BUS_SEQ -- requirements
Module: bus_seq

Interface
- REQ-001 SHALL have parameter AW, default 16, address width.
- REQ-002 SHALL have parameter DW, default 8, data width.
- REQ-003 SHALL have parameter TCYC, default 4, T-states per M-cycle; legal values are even and >=4.
- REQ-004 SHALL have parameter MAX_WAIT, default 15, maximum wait states before timeout; legal range is 1..255.
- REQ-005 SHALL use one clock and a synchronous, active-high reset.
- REQ-006 SHALL have ports:
  - clk  in  1  clock; all logic on rising edge.
  - rst  in  1  synchronous reset, active high.
  - req_valid  in  1  request present.
  - req_op  in  2  request type: 00 idle, 01 fetch, 10 write, 11 read.
  - req_addr  in  AW  request address.
  - req_wdata  in  DW  write data.
  - req_ready  out  1  request accept window.
  - a  out  AW  external address bus.
  - dout  out  DW  external write data.
  - din  in  DW  external read data.
  - rd  out  1  read strobe.
  - wr  out  1  write strobe.
  - phi  out  1  phase clock.
  - ready  in  1  external ready; 0 inserts wait states.
  - opcode  out  DW  last fetched byte.
  - rdata  out  DW  last read byte.
  - rsp_valid  out  1  one-cycle completion pulse.
  - rsp_err  out  1  completion was a timeout; valid only with rsp_valid.
  - tstate  out  $clog2(TCYC)  current T-state.

Function
- REQ-007 SHALL keep a T-state counter that steps 0..TCYC-1 and wraps to 0, advancing every clock except during a wait stall.
- REQ-008 SHALL drive req_ready=1 combinationally exactly when tstate==0.
- REQ-009 SHALL, on the edge leaving tstate 0:
  - if req_valid=1, latch req_op, req_addr and req_wdata;
  - if req_valid=0, latch op=idle.
- REQ-010 SHALL ignore req_valid whenever tstate!=0.
- REQ-011 SHALL update registered outputs on the edge entering tstate 1 as follows: a<=latched addr (non-idle ops only; idle leaves a unchanged); rd<=1 for fetch or read, else 0; wr<=0; phi<=1.
- REQ-012 SHALL hold phi=1 for tstates 1..TCYC/2 and phi=0 for all other tstates.
- REQ-013 SHALL, for a write, set wr<=1 and dout<=latched wdata on the edge entering tstate TCYC-1.
- REQ-014 SHALL treat tstate TCYC-1 as the completion state. An edge in this state completes the M-cycle when ready=1, or when op=idle.
- REQ-015 SHALL do the following at the completing edge:
  - fetch: opcode<=din.
  - read: rdata<=din.
  - all ops: rd<=0, wr<=0, dout<=0, tstate<=0.
  - non-idle ops only: rsp_valid<=1 and rsp_err<=0.
- REQ-016 SHALL stall when ready=0 in tstate TCYC-1 with a non-idle op. During a stall: tstate holds; a, rd, wr, dout and phi hold; the wait counter increments by 1.
- REQ-017 SHALL time out when a stall edge occurs with the wait counter equal to MAX_WAIT. On that edge it completes as in REQ-015 except that opcode and rdata are unchanged and rsp_err<=1.
- REQ-018 SHALL clear the wait counter on every edge leaving tstate 0.
- REQ-019 SHALL drive rsp_valid high for exactly one clock per non-idle request, and never for an idle op.
- REQ-020 SHALL hold opcode and rdata between captures.
- REQ-021 SHALL make one full M-cycle take TCYC+N clocks, where N is the number of wait states (N<=MAX_WAIT).
- REQ-022 SHALL, when ready goes 1 on the same edge that would reach the timeout (wait counter == MAX_WAIT), complete normally with rsp_err=0 and capture din.

Reset
- REQ-023 SHALL, when rst=1 at a clock edge, set: tstate=0, a=0, dout=0, rd=0, wr=0, phi=0, opcode=0, rdata=0, rsp_valid=0, rsp_err=0, wait counter=0, latched op=idle.
- REQ-024 SHALL abandon any in-flight request on reset at any tstate, including mid-stall, without issuing rsp_valid.
- REQ-025 SHALL, with rst low, sample the first request in tstate 0 on the following clock.

Verification (TCYC=4, MAX_WAIT=3)
- REQ-026 Fetch: req_op=01, addr=0x0150, din=0x3E, ready=1 -> tstate 1: rd=1, a=0x0150, phi=1; opcode=0x3E and rsp_valid pulse 4 clocks after acceptance.
- REQ-027 Write: req_op=10, addr=0xC000, wdata=0xA5 -> wr=1 and dout=0xA5 only in tstate 3; rd=0 throughout; rsp_valid once.
- REQ-028 Read, 2 waits: req_op=11, ready low for 2 edges in tstate 3, then din=0x5A with ready=1 -> rdata=0x5A; cycle length 6 clocks; rsp_err=0.
- REQ-029 Timeout: read with ready held 0 -> completes after 3 wait states with rsp_err=1; rdata unchanged; next M-cycle starts at tstate 0.
- REQ-030 Idle plus late request: req_valid=0 in tstate 0, asserted in tstate 2 -> no rd/wr, no rsp_valid; request accepted only in the next tstate 0.
- REQ-031 Reset mid-stall: rst=1 while stalled in tstate 3 -> next cycle all outputs 0 and tstate=0; no rsp_valid.

Source files
------------

// File: rtl/bus_seq.sv
// Bus M-cycle sequencer: one request per M-cycle of TCYC T-states, wait states via ready, timeout after MAX_WAIT.
// Latency: TCYC+N clocks per M-cycle (N wait states); rsp_valid pulses on the clock after the completing edge.
// Backpressure: requests are taken only in T-state 0 (req_ready); ready=0 in the last T-state stalls the cycle.
module bus_seq #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int TCYC     = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [1:0]              req_op,
    input  logic [AW-1:0]           req_addr,
    input  logic [DW-1:0]           req_wdata,
    output logic                    req_ready,
    output logic [AW-1:0]           a,
    output logic [DW-1:0]           dout,
    input  logic [DW-1:0]           din,
    output logic                    rd,
    output logic                    wr,
    output logic                    phi,
    input  logic                    ready,
    output logic [DW-1:0]           opcode,
    output logic [DW-1:0]           rdata,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [$clog2(TCYC)-1:0] tstate
);
    localparam int              TW        = $clog2(TCYC);
    localparam logic [TW-1:0]   T_LAST    = TW'(TCYC - 1);
    localparam logic [TW-1:0]   T_PHI_END = TW'(TCYC / 2);
    localparam logic [7:0]      WAIT_MAX  = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_FETCH = 2'b01,
        OP_WRITE = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    op_t            op_q, op_n, in_op;
    logic [DW-1:0]  wdata_q, wdata_n;
    logic [7:0]     wait_q, wait_n;
    logic [TW-1:0]  tstate_n, ts_inc;
    logic [AW-1:0]  a_n;
    logic [DW-1:0]  dout_n, opcode_n, rdata_n;
    logic           rd_n, wr_n, phi_n, rsp_valid_n, rsp_err_n;
    logic           done, tmo;

    assign req_ready = (tstate == '0);
    assign in_op     = req_valid ? op_t'(req_op) : OP_IDLE;
    assign ts_inc    = tstate + TW'(1);
    // An idle M-cycle never waits; a stall at the wait limit ends the cycle as a timeout.
    assign done      = (op_q == OP_IDLE) || ready;
    assign tmo       = !done && (wait_q == WAIT_MAX);

    always_comb begin
        op_n        = op_q;
        wdata_n     = wdata_q;
        wait_n      = wait_q;
        tstate_n    = tstate;
        a_n         = a;
        dout_n      = dout;
        rd_n        = rd;
        wr_n        = wr;
        phi_n       = phi;
        opcode_n    = opcode;
        rdata_n     = rdata;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;

        if (tstate == '0) begin
            op_n     = in_op;
            if (req_valid) begin
                wdata_n = req_wdata;
            end
            wait_n   = '0;
            tstate_n = TW'(1);
            phi_n    = 1'b1;
            wr_n     = 1'b0;
            rd_n     = (in_op == OP_FETCH) || (in_op == OP_READ);
            if (in_op != OP_IDLE) begin
                a_n = req_addr;
            end
        end else if (tstate == T_LAST) begin
            if (done || tmo) begin
                tstate_n = '0;
                rd_n     = 1'b0;
                wr_n     = 1'b0;
                dout_n   = '0;
                phi_n    = 1'b0;
                if (done && (op_q == OP_FETCH)) begin
                    opcode_n = din;
                end
                if (done && (op_q == OP_READ)) begin
                    rdata_n = din;
                end
                if (op_q != OP_IDLE) begin
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = tmo;
                end
            end else begin
                wait_n = wait_q + 8'd1;
            end
        end else begin
            tstate_n = ts_inc;
            phi_n    = (ts_inc <= T_PHI_END);
            if ((ts_inc == T_LAST) && (op_q == OP_WRITE)) begin
                wr_n   = 1'b1;
                dout_n = wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_IDLE;
            wdata_q   <= '0;
            wait_q    <= '0;
            tstate    <= '0;
            a         <= '0;
            dout      <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            phi       <= 1'b0;
            opcode    <= '0;
            rdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            op_q      <= op_n;
            wdata_q   <= wdata_n;
            wait_q    <= wait_n;
            tstate    <= tstate_n;
            a         <= a_n;
            dout      <= dout_n;
            rd        <= rd_n;
            wr        <= wr_n;
            phi       <= phi_n;
            opcode    <= opcode_n;
            rdata     <= rdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
        end
    end
endmodule

// File: tb/tb_bus_seq.sv
// Randomized bench for bus_seq: each M-cycle is predicted from its op and wait count as a per-clock timeline.
module tb_bus_seq;
    localparam int AW       = 16;
    localparam int DW       = 8;
    localparam int TCYC     = 4;
    localparam int MAX_WAIT = 3;

    logic          clk, rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr, a;
    logic [DW-1:0] req_wdata, dout, din, opcode, rdata;
    logic          rd, wr, phi, ready, rsp_valid, rsp_err;
    logic [1:0]    tstate;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] a_exp;
    logic [DW-1:0] opcode_exp, rdata_exp;
    bit            pend, pend_err;

    bus_seq #(.AW(AW), .DW(DW), .TCYC(TCYC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .a(a), .dout(dout), .din(din), .rd(rd), .wr(wr), .phi(phi), .ready(ready),
        .opcode(opcode), .rdata(rdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .tstate(tstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One M-cycle. waits > MAX_WAIT means ready never comes (timeout).
    // rst_at >= 0 asserts reset before the edge ending clock index rst_at.
    task automatic run_txn(input logic v, input logic [1:0] op, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] cdin,
                           input int rst_at);
        logic [1:0] eop;
        bit idle, tmo, is_rd, is_wr;
        int w, len, ts;
        eop   = v ? op : 2'b00;
        idle  = (eop == 2'b00);
        tmo   = !idle && (waits > MAX_WAIT);
        w     = idle ? 0 : (tmo ? MAX_WAIT : waits);
        len   = TCYC + w;
        is_rd = (eop == 2'b01) || (eop == 2'b11);
        is_wr = (eop == 2'b10);
        for (int k = 0; k < len; k++) begin
            if (k == 0) begin
                req_valid = v; req_op = op; req_addr = ad; req_wdata = wd;
            end else begin
                req_valid = 1'($urandom); req_op = 2'($urandom);
                req_addr = 16'($urandom); req_wdata = 8'($urandom);
            end
            if (k < TCYC - 1 || idle) ready = 1'($urandom);
            else ready = ((k - (TCYC - 1)) >= waits);
            din = (k == len - 1) ? cdin : 8'($urandom);
            rst = (k == rst_at);
            #4;
            ts = (k < TCYC - 1) ? k : TCYC - 1;
            chk("tstate", 32'(tstate), 32'(ts));
            chk("req_ready", 32'(req_ready), 32'(k == 0));
            chk("phi", 32'(phi), 32'(k >= 1 && k <= TCYC / 2));
            chk("rd", 32'(rd), 32'(is_rd && k >= 1));
            chk("wr", 32'(wr), 32'(is_wr && k >= TCYC - 1));
            chk("dout", 32'(dout), (is_wr && k >= TCYC - 1) ? 32'(wd) : 32'd0);
            chk("a", 32'(a), 32'(a_exp));
            chk("opcode", 32'(opcode), 32'(opcode_exp));
            chk("rdata", 32'(rdata), 32'(rdata_exp));
            chk("rsp_valid", 32'(rsp_valid), 32'(k == 0 && pend));
            if (k == 0 && pend) chk("rsp_err", 32'(rsp_err), 32'(pend_err));
            if (k == 0) pend = 1'b0;
            @(posedge clk); #1;
            if (k == 0 && !idle) a_exp = ad;
            if (k == rst_at) begin
                rst = 1'b0;
                a_exp = '0; opcode_exp = '0; rdata_exp = '0; pend = 1'b0;
                return;
            end
        end
        if (!idle) begin
            pend = 1'b1;
            pend_err = tmo;
            if (!tmo && eop == 2'b01) opcode_exp = cdin;
            if (!tmo && eop == 2'b11) rdata_exp = cdin;
        end
    endtask

    initial begin
        int wt, ra;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
        din = '0; ready = 1'b1;
        a_exp = '0; opcode_exp = '0; rdata_exp = '0; pend = 1'b0; pend_err = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_tstate", 32'(tstate), 32'd0);
        chk("rst_outs", {20'd0, rd, wr, phi, rsp_valid, rsp_err, dout}, 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(1'b1, 2'b01, 16'h0150, 8'h00, 0, 8'h3E, -1);        // fetch
        run_txn(1'b1, 2'b10, 16'hC000, 8'hA5, 0, 8'h11, -1);        // write
        run_txn(1'b1, 2'b11, 16'h1234, 8'h00, 2, 8'h5A, -1);        // read, 2 waits
        run_txn(1'b1, 2'b11, 16'h2000, 8'h00, MAX_WAIT + 1, 8'hEE, -1); // timeout
        run_txn(1'b0, 2'b01, 16'h3333, 8'h00, 0, 8'h99, -1);        // idle, junk later
        run_txn(1'b1, 2'b11, 16'h4444, 8'h00, MAX_WAIT, 8'h77, -1); // ready at the limit
        run_txn(1'b1, 2'b01, 16'h5555, 8'h00, 0, 8'hC3, -1);
        run_txn(1'b1, 2'b11, 16'h6666, 8'h00, MAX_WAIT + 1, 8'h00, TCYC); // reset mid-stall
        run_txn(1'b1, 2'b00, 16'h7777, 8'h00, 0, 8'h42, -1);        // valid with op idle
        for (int i = 0; i < 60; i++) begin
            wt = $urandom_range(0, MAX_WAIT + 1);
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TCYC + MAX_WAIT - 1) : -1;
            run_txn(($urandom_range(0, 7) != 0), 2'($urandom), 16'($urandom), 8'($urandom),
                    wt, 8'($urandom), ra);
        end
        run_txn(1'b0, 2'b00, 16'h0000, 8'h00, 0, 8'h00, -1);
        run_txn(1'b0, 2'b00, 16'h0000, 8'h00, 0, 8'h00, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
